// File: rtl/pico_pkg.sv
// Shared picoMips types: run-control state encoding and instruction opcodes.
package pico_pkg;

    typedef enum logic [1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        BRK  = 2'd3
    } run_state_t;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_ADD  = 3'd0;
    localparam logic [OP_W-1:0] OP_MOV  = 3'd1;
    localparam logic [OP_W-1:0] OP_MULI = 3'd2;
    localparam logic [OP_W-1:0] OP_ADDI = 3'd3;
    localparam logic [OP_W-1:0] OP_HEI  = 3'd4;

endpackage

// File: rtl/pico_sync2.sv
// Two-flop synchroniser for a single asynchronous switch input.
module pico_sync2 (
    input  logic Clock,
    input  logic nReset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pico_run_ctrl.sv
// Run/halt/step/breakpoint sequencer for the picoMips core: gates PC advance
// and register writes, counts retired instructions and wraps the PC.
module pico_run_ctrl
    import pico_pkg::*;
#(
    parameter int unsigned PC_W      = 5,
    parameter int unsigned PROG_LEN  = 22,
    parameter int unsigned CYC_W     = 16,
    parameter int unsigned START_RUN = 1
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             run_i,
    input  logic             halt_i,
    input  logic             step_i,
    input  logic             bp_en_i,
    input  logic [PC_W-1:0]  bp_addr_i,
    input  logic             sw8_async_i,
    input  logic             hold_i,
    input  logic [PC_W-1:0]  pc_i,
    output logic             pc_en_o,
    output logic             pc_wrap_o,
    output logic             wr_en_o,
    output logic             sw8_sync_o,
    output logic [1:0]       state_o,
    output logic             bp_hit_o,
    output logic [CYC_W-1:0] cycle_cnt_o
);

    localparam run_state_t      RESET_STATE = (START_RUN != 0) ? RUN : HALT;
    localparam logic [PC_W-1:0] LAST_PC     = PC_W'(PROG_LEN - 1);

    run_state_t state;
    logic       resume;
    logic       bp_stop;
    logic       step_abort;
    logic       exec;

    pico_sync2 u_sw8_sync (
        .Clock  (Clock),
        .nReset (nReset),
        .d      (sw8_async_i),
        .q      (sw8_sync_o)
    );

    assign state_o = state;

    // Execution gating; held at zero while reset is asserted.
    always_comb begin
        bp_stop    = 1'b0;
        step_abort = 1'b0;
        exec       = 1'b0;
        bp_stop    = (state == RUN) && bp_en_i && (pc_i == bp_addr_i) && !resume;
        step_abort = (state == STEP) && halt_i;
        exec       = nReset && ((state == RUN) || (state == STEP)) && !bp_stop && !step_abort;
        wr_en_o    = exec;
        pc_en_o    = exec && !hold_i;
        pc_wrap_o  = pc_en_o && (pc_i == LAST_PC);
    end

    // State machine, breakpoint flag, resume flag and retirement counter.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state       <= RESET_STATE;
            bp_hit_o    <= 1'b0;
            resume      <= 1'b0;
            cycle_cnt_o <= '0;
        end else begin
            if (pc_en_o && (cycle_cnt_o != '1)) begin
                cycle_cnt_o <= cycle_cnt_o + CYC_W'(1);
            end
            if (pc_en_o) begin
                resume <= 1'b0;
            end
            case (state)
                RUN: begin
                    if (halt_i) begin
                        state <= HALT;
                    end else if (bp_stop) begin
                        state    <= BRK;
                        bp_hit_o <= 1'b1;
                    end
                end
                STEP: begin
                    if (halt_i || pc_en_o) begin
                        state <= HALT;
                    end
                end
                HALT, BRK: begin
                    // resume lets the instruction under the breakpoint retire once
                    if (halt_i) begin
                        state <= state;
                    end else if (step_i) begin
                        state    <= STEP;
                        resume   <= 1'b1;
                        bp_hit_o <= 1'b0;
                    end else if (run_i) begin
                        state    <= RUN;
                        resume   <= 1'b1;
                        bp_hit_o <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pico_run_ctrl.sv
// Scoreboard bench for pico_run_ctrl: directed stimulus queues per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_pico_run_ctrl;
    import pico_pkg::*;

    localparam int F_STATE = 0;
    localparam int F_PCEN  = 1;
    localparam int F_WREN  = 2;
    localparam int F_WRAP  = 3;
    localparam int F_BPHIT = 4;
    localparam int F_CNT   = 5;
    localparam int F_SYNC  = 6;
    localparam int F_CNT4  = 7;

    typedef struct {
        int          cyc;
        int          fld;
        logic [15:0] val;
        string       name;
    } exp_t;

    logic        Clock = 1'b0;
    logic        nReset;
    logic        run_i, halt_i, step_i, bp_en_i, sw8_async_i, hold_i;
    logic [4:0]  bp_addr_i, pc_i;
    logic        pc_en_o, pc_wrap_o, wr_en_o, sw8_sync_o, bp_hit_o;
    logic [1:0]  state_o;
    logic [15:0] cycle_cnt_o;

    logic        zero1 = 1'b0;
    logic [4:0]  zero5 = 5'd0;
    logic        s_pc_en, s_wrap, s_wr_en, s_sync, s_bp_hit;
    logic [1:0]  s_state;
    logic [3:0]  s_cnt;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          ecnt = 0;
    bit          adv = 1'b0;

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    pico_run_ctrl #(.PC_W(5), .PROG_LEN(22), .CYC_W(16), .START_RUN(1)) dut (
        .Clock(Clock), .nReset(nReset), .run_i(run_i), .halt_i(halt_i), .step_i(step_i),
        .bp_en_i(bp_en_i), .bp_addr_i(bp_addr_i), .sw8_async_i(sw8_async_i), .hold_i(hold_i),
        .pc_i(pc_i), .pc_en_o(pc_en_o), .pc_wrap_o(pc_wrap_o), .wr_en_o(wr_en_o),
        .sw8_sync_o(sw8_sync_o), .state_o(state_o), .bp_hit_o(bp_hit_o), .cycle_cnt_o(cycle_cnt_o)
    );

    // Small-counter instance: free-running, used only for saturation.
    pico_run_ctrl #(.PC_W(5), .PROG_LEN(22), .CYC_W(4), .START_RUN(1)) u_sat (
        .Clock(Clock), .nReset(nReset), .run_i(zero1), .halt_i(zero1), .step_i(zero1),
        .bp_en_i(zero1), .bp_addr_i(zero5), .sw8_async_i(zero1), .hold_i(zero1),
        .pc_i(zero5), .pc_en_o(s_pc_en), .pc_wrap_o(s_wrap), .wr_en_o(s_wr_en),
        .sw8_sync_o(s_sync), .state_o(s_state), .bp_hit_o(s_bp_hit), .cycle_cnt_o(s_cnt)
    );

    function automatic logic [15:0] sample(input int fld);
        case (fld)
            F_STATE: return 16'(state_o);
            F_PCEN:  return 16'(pc_en_o);
            F_WREN:  return 16'(wr_en_o);
            F_WRAP:  return 16'(pc_wrap_o);
            F_BPHIT: return 16'(bp_hit_o);
            F_CNT:   return cycle_cnt_o;
            F_SYNC:  return 16'(sw8_sync_o);
            default: return 16'(s_cnt);
        endcase
    endfunction

    always @(negedge Clock) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            logic [15:0] act;
            e   = sb.pop_front();
            act = sample(e.fld);
            n_checks++;
            if (e.cyc != cyc || act !== e.val) begin
                n_errors++;
                $display("FAIL %s cycle %0d: got %0d, expected %0d", e.name, e.cyc, act, e.val);
            end
        end
    end

    task automatic push(input int fld, input logic [15:0] val, input string name);
        exp_t e;
        e.cyc  = cyc;
        e.fld  = fld;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
        run_i  = 1'b0;
        halt_i = 1'b0;
        step_i = 1'b0;
        if (adv) pc_i = (pc_i == 5'd21) ? 5'd0 : pc_i + 5'd1;
        adv = 1'b0;
    endtask

    // Queue the expected outputs of the current cycle, then advance one clock.
    task automatic exp_cycle(input logic [1:0] st, input bit en, input bit wr, input bit bph,
                             input string tag);
        push(F_STATE, 16'(st), {tag, ".state"});
        push(F_PCEN, 16'(en), {tag, ".pc_en"});
        push(F_WREN, 16'(wr), {tag, ".wr_en"});
        push(F_BPHIT, 16'(bph), {tag, ".bp_hit"});
        push(F_WRAP, 16'(en && (pc_i == 5'd21)), {tag, ".pc_wrap"});
        push(F_CNT, 16'(ecnt), {tag, ".cycle_cnt"});
        if (en) ecnt++;
        adv = en;
        tick();
    endtask

    initial begin
        nReset = 1'b0;
        {run_i, halt_i, step_i, bp_en_i, sw8_async_i, hold_i} = '0;
        bp_addr_i = 5'd0;
        pc_i = 5'd0;

        tick();
        n_checks++;
        if (state_o !== 2'(RUN)) begin
            n_errors++;
            $display("FAIL rst_direct.state: got %0d, expected %0d", state_o, RUN);
        end
        n_checks++;
        if (cycle_cnt_o !== 16'd0) begin
            n_errors++;
            $display("FAIL rst_direct.cycle_cnt: got %0d, expected 0", cycle_cnt_o);
        end
        n_checks++;
        if (pc_en_o !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_direct.pc_en: got %0d, expected 0", pc_en_o);
        end
        push(F_STATE, 16'(RUN), "rst.state");
        push(F_PCEN, 16'd0, "rst.pc_en");
        push(F_WREN, 16'd0, "rst.wr_en");
        push(F_BPHIT, 16'd0, "rst.bp_hit");
        push(F_CNT, 16'd0, "rst.cycle_cnt");
        push(F_SYNC, 16'd0, "rst.sw8_sync");
        push(F_CNT4, 16'd0, "rst.cnt4");
        tick();
        nReset = 1'b1;

        // Free run from reset: count, wrap at 21, sw8 latency, 4-bit saturation.
        for (int k = 0; k < 24; k++) begin
            if (k == 3) sw8_async_i = 1'b1;
            push(F_SYNC, 16'(k >= 5), "sw8_sync");
            if (k == 14) push(F_CNT4, 16'd14, "cnt4_14");
            if (k == 20) push(F_CNT4, 16'd15, "cnt4_sat");
            if (k == 23) push(F_CNT4, 16'd15, "cnt4_hold");
            exp_cycle(RUN, 1, 1, 0, "run");
        end

        // Breakpoint at 7, resume past it, break again on the next lap.
        bp_en_i   = 1'b1;
        bp_addr_i = 5'd7;
        for (int k = 2; k < 7; k++) exp_cycle(RUN, 1, 1, 0, "pre_bp");
        exp_cycle(RUN, 0, 0, 0, "bp_stop");
        exp_cycle(BRK, 0, 0, 1, "brk");
        run_i = 1'b1;
        exp_cycle(BRK, 0, 0, 1, "brk_run");
        exp_cycle(RUN, 1, 1, 0, "resume");
        for (int k = 0; k < 21; k++) exp_cycle(RUN, 1, 1, 0, "lap");
        exp_cycle(RUN, 0, 0, 0, "bp_stop2");

        // BRK ignores halt; run then halt lands in HALT.
        halt_i = 1'b1;
        exp_cycle(BRK, 0, 0, 1, "brk_halt");
        exp_cycle(BRK, 0, 0, 1, "brk_stay");
        bp_en_i = 1'b0;
        run_i   = 1'b1;
        exp_cycle(BRK, 0, 0, 1, "brk_run2");
        exp_cycle(RUN, 1, 1, 0, "resume2");
        halt_i = 1'b1;
        exp_cycle(RUN, 1, 1, 0, "run_halt");
        exp_cycle(HALT, 0, 0, 0, "halted");

        // Coincident pulses, then single step through an HEI hold.
        {halt_i, step_i, run_i} = 3'b111;
        exp_cycle(HALT, 0, 0, 0, "all3");
        exp_cycle(HALT, 0, 0, 0, "all3_after");
        {step_i, run_i} = 2'b11;
        hold_i = 1'b1;
        exp_cycle(HALT, 0, 0, 0, "step_run");
        for (int k = 0; k < 3; k++) exp_cycle(STEP, 0, 1, 0, "step_hold");
        hold_i = 1'b0;
        exp_cycle(STEP, 1, 1, 0, "step_ret");
        exp_cycle(HALT, 0, 0, 0, "step_done");
        step_i = 1'b1;
        exp_cycle(HALT, 0, 0, 0, "step2");
        halt_i = 1'b1;
        exp_cycle(STEP, 0, 0, 0, "step_abort");
        exp_cycle(HALT, 0, 0, 0, "abort_done");

        // Asynchronous reset in the middle of a held step.
        step_i = 1'b1;
        exp_cycle(HALT, 0, 0, 0, "step3");
        hold_i = 1'b1;
        exp_cycle(STEP, 0, 1, 0, "hold3");
        #1;
        nReset = 1'b0;
        #1;
        n_checks++;
        if (state_o !== 2'(RUN)) begin
            n_errors++;
            $display("FAIL arst_direct.state: got %0d, expected %0d", state_o, RUN);
        end
        n_checks++;
        if (cycle_cnt_o !== 16'd0) begin
            n_errors++;
            $display("FAIL arst_direct.cycle_cnt: got %0d, expected 0", cycle_cnt_o);
        end
        push(F_STATE, 16'(RUN), "arst.state");
        push(F_CNT, 16'd0, "arst.cycle_cnt");
        push(F_PCEN, 16'd0, "arst.pc_en");
        push(F_SYNC, 16'd0, "arst.sw8_sync");
        tick();
        nReset = 1'b1;
        hold_i = 1'b0;
        pc_i   = 5'd0;
        ecnt   = 0;
        for (int k = 0; k < 3; k++) exp_cycle(RUN, 1, 1, 0, "post_rst");

        @(negedge Clock);
        @(negedge Clock);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_checks++;
            n_errors++;
            $display("FAIL %s cycle %0d: never compared, expected %0d", e.name, e.cyc, e.val);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
